sobel_window_buffer: RTL

- Downstream neighbour of the colorspace converter in the edge-detection pipeline.
- Consumes the raster-ordered grayscale pixel stream (pixel, column, row, write-enable) from the converter.
- Stores the two previous rows in line buffers and emits a registered 3x3 pixel window with the window-centre coordinates.
- The Sobel gradient stage consumes its output.

---
 rtl/sobel_window_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/sobel_window_buffer.sv
// Two-row line buffer and 3x3 window generator feeding the Sobel gradient stage.
// Optional raster-order checker: define SOBEL_WINDOW_ORDER_CHECK_EN.
module sobel_window_buffer #(
  parameter int P_COLUMNS     = 640,
  parameter int P_ROWS        = 480,
  parameter int P_PIXEL_DEPTH = 8
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
  input  logic [$clog2(P_COLUMNS)-1:0] I_PIXEL_COL,
  input  logic [$clog2(P_ROWS)-1:0]    I_PIXEL_ROW,
  input  logic                         I_PIXEL_WRITE_ENABLE,
  output logic [9*P_PIXEL_DEPTH-1:0]   O_WINDOW,
  output logic [$clog2(P_COLUMNS)-1:0] O_CENTER_COL,
  output logic [$clog2(P_ROWS)-1:0]    O_CENTER_ROW,
  output logic                         O_WINDOW_VALID,
  output logic                         O_ORDER_ERROR
);

  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_ROWS);

  typedef logic [P_PIXEL_DEPTH-1:0] pixel_t;

  pixel_t lb0 [P_COLUMNS];   // row r-1
  pixel_t lb1 [P_COLUMNS];   // row r-2
  pixel_t win [9];           // element k = 3*row + col

  logic   accept;
  pixel_t lb0_rd;
  pixel_t lb1_rd;

  assign accept = I_ENABLE & I_PIXEL_WRITE_ENABLE;
  assign lb0_rd = lb0[I_PIXEL_COL];
  assign lb1_rd = lb1[I_PIXEL_COL];

  // NOTE: line-buffer RAMs carry no reset so they can map onto block memory;
  // rows 0 and 1 of every frame refill them before any window is flagged valid.
  always_ff @(posedge I_CLK) begin
    if (accept) begin
      lb1[I_PIXEL_COL] <= lb0_rd;
      lb0[I_PIXEL_COL] <= I_PIXEL;
    end
  end

  // NOTE: non-blocking assignments make every tap read its pre-shift value,
  // so the loop order below does not matter.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[3*r]   <= win[3*r+1];
        win[3*r+1] <= win[3*r+2];
      end
      win[2] <= lb1_rd;
      win[5] <= lb0_rd;
      win[8] <= I_PIXEL;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign O_WINDOW[k*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] = win[k];
  end

  // Columns 0/1 of each row only refill the window, so stale data is never flagged.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      O_WINDOW_VALID <= 1'b0;
      O_CENTER_COL   <= '0;
      O_CENTER_ROW   <= '0;
    end else begin
      O_WINDOW_VALID <= accept && (I_PIXEL_COL >= CW'(2)) && (I_PIXEL_ROW >= RW'(2));
      if (accept) begin
        O_CENTER_COL <= I_PIXEL_COL - CW'(1);
        O_CENTER_ROW <= I_PIXEL_ROW - RW'(1);
      end
    end
  end

`ifdef SOBEL_WINDOW_ORDER_CHECK_EN
  logic [CW-1:0] last_col;
  logic [RW-1:0] last_row;
  logic          have_last;
  logic          at_row_end;
  logic          is_next;
  logic          is_restart;

  assign at_row_end = (last_col == CW'(P_COLUMNS - 1));
  assign is_restart = (I_PIXEL_COL == '0) && (I_PIXEL_ROW == '0);
  assign is_next    = at_row_end
                    ? ((I_PIXEL_COL == '0) && (I_PIXEL_ROW == last_row + RW'(1)))
                    : ((I_PIXEL_COL == last_col + CW'(1)) && (I_PIXEL_ROW == last_row));

  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      last_col      <= '0;
      last_row      <= '0;
      have_last     <= 1'b0;
      O_ORDER_ERROR <= 1'b0;
    end else if (accept) begin
      last_col  <= I_PIXEL_COL;
      last_row  <= I_PIXEL_ROW;
      have_last <= 1'b1;
      if (have_last && !is_next && !is_restart) O_ORDER_ERROR <= 1'b1;
    end
  end
`else
  assign O_ORDER_ERROR = 1'b0;
`endif

endmodule
